// File: rtl/mc_datapath.sv
`default_nettype none
// ============================================================================
// Module   : mc_datapath
// Purpose  : Multi-cycle MIPS-subset datapath. Each instruction walks through
//            FETCH/DECODE/EXEC/MEM/WB as needed; instruction and data memories
//            sit outside behind req/ack handshakes, register file is internal.
// Revision : 1.0 - initial release
// ============================================================================
module mc_datapath #(
    parameter int          DATA_W   = 32,
    parameter int          ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic [31:0]       imem_rdata,
    input  logic              imem_ack,
    output logic              dmem_req,
    output logic              dmem_we,
    output logic [ADDR_W-1:0] dmem_addr,
    output logic [DATA_W-1:0] dmem_wdata,
    input  logic [DATA_W-1:0] dmem_rdata,
    input  logic              dmem_ack,
    output logic [ADDR_W-1:0] pc_o,
    output logic              retire,
    output logic              illegal
);

    localparam logic [5:0] OP_R    = 6'h00;
    localparam logic [5:0] OP_J    = 6'h02;
    localparam logic [5:0] OP_BEQ  = 6'h04;
    localparam logic [5:0] OP_ADDI = 6'h08;
    localparam logic [5:0] OP_LW   = 6'h23;
    localparam logic [5:0] OP_SW   = 6'h2B;

    localparam logic [5:0] FN_ADD  = 6'h20;
    localparam logic [5:0] FN_SUB  = 6'h22;
    localparam logic [5:0] FN_AND  = 6'h24;
    localparam logic [5:0] FN_OR   = 6'h25;
    localparam logic [5:0] FN_SLT  = 6'h2A;

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4
    } state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   pc_q, pc_d;
    logic [31:0]         ir_q, ir_d;
    logic [DATA_W-1:0]   a_q, a_d;
    logic [DATA_W-1:0]   b_q, b_d;
    logic [DATA_W-1:0]   aluout_q, aluout_d;
    logic [DATA_W-1:0]   mdr_q, mdr_d;
    logic [DATA_W-1:0]   regs_q [32];

    // Instruction fields
    logic [5:0]          w_op;
    logic [4:0]          w_rs, w_rt, w_rd;
    logic [5:0]          w_funct;
    logic signed [15:0]  w_imm_s;
    logic [DATA_W-1:0]   w_sext;
    logic                w_unused_shamt;

    assign w_op           = ir_q[31:26];
    assign w_rs           = ir_q[25:21];
    assign w_rt           = ir_q[20:16];
    assign w_rd           = ir_q[15:11];
    assign w_funct        = ir_q[5:0];
    assign w_imm_s        = ir_q[15:0];
    assign w_sext         = DATA_W'(w_imm_s);
    assign w_unused_shamt = ^ir_q[10:6];

    // Register file read ports; R0 is hardwired to zero
    logic [DATA_W-1:0]   w_rf_rs, w_rf_rt;
    assign w_rf_rs = (w_rs == 5'd0) ? '0 : regs_q[w_rs];
    assign w_rf_rt = (w_rt == 5'd0) ? '0 : regs_q[w_rt];

    // Decode legality
    logic w_is_r, w_funct_ok, w_legal;
    assign w_is_r     = (w_op == OP_R);
    assign w_funct_ok = (w_funct == FN_ADD) || (w_funct == FN_SUB) ||
                        (w_funct == FN_AND) || (w_funct == FN_OR)  ||
                        (w_funct == FN_SLT);
    assign w_legal    = (w_is_r && w_funct_ok) || (w_op == OP_ADDI) ||
                        (w_op == OP_LW) || (w_op == OP_SW) ||
                        (w_op == OP_BEQ) || (w_op == OP_J);

    // Jump target keeps PC bits above 28 (PC already advanced) and replaces the rest
    logic [ADDR_W-1:0] w_jtgt;
    assign w_jtgt = (pc_q & ~ADDR_W'(32'h0FFF_FFFF)) | ADDR_W'({ir_q[25:0], 2'b00});

    // R-type ALU
    logic [DATA_W-1:0] w_alu_r;
    always_comb begin
        w_alu_r = '0;
        case (w_funct)
            FN_ADD:  w_alu_r = a_q + b_q;
            FN_SUB:  w_alu_r = a_q - b_q;
            FN_AND:  w_alu_r = a_q & b_q;
            FN_OR:   w_alu_r = a_q | b_q;
            FN_SLT:  w_alu_r = DATA_W'($signed(a_q) < $signed(b_q));
            default: w_alu_r = '0;
        endcase
    end

    logic              w_imem_req, w_dmem_req, w_dmem_we, w_retire, w_illegal;
    logic              w_rf_we;
    logic [4:0]        w_rf_waddr;
    logic [DATA_W-1:0] w_rf_wdata;

    // Next-state, datapath next values and control outputs
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        ir_d       = ir_q;
        a_d        = a_q;
        b_d        = b_q;
        aluout_d   = aluout_q;
        mdr_d      = mdr_q;
        w_imem_req = 1'b0;
        w_dmem_req = 1'b0;
        w_dmem_we  = 1'b0;
        w_retire   = 1'b0;
        w_illegal  = 1'b0;
        w_rf_we    = 1'b0;
        w_rf_waddr = 5'd0;
        w_rf_wdata = '0;
        case (state_q)
            S_FETCH: begin
                w_imem_req = 1'b1;
                if (imem_ack) begin
                    ir_d    = imem_rdata;
                    pc_d    = pc_q + ADDR_W'(4);
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                a_d      = w_rf_rs;
                b_d      = w_rf_rt;
                aluout_d = DATA_W'(pc_q) + (w_sext << 2);
                if (!w_legal) begin
                    w_illegal = 1'b1;
                    w_retire  = 1'b1;
                    state_d   = S_FETCH;
                end else if (w_op == OP_J) begin
                    pc_d     = w_jtgt;
                    w_retire = 1'b1;
                    state_d  = S_FETCH;
                end else begin
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                case (w_op)
                    OP_R: begin
                        aluout_d = w_alu_r;
                        state_d  = S_WB;
                    end
                    OP_ADDI: begin
                        aluout_d = a_q + w_sext;
                        state_d  = S_WB;
                    end
                    OP_LW, OP_SW: begin
                        aluout_d = a_q + w_sext;
                        state_d  = S_MEM;
                    end
                    OP_BEQ: begin
                        if (a_q == b_q) begin
                            pc_d = aluout_q[ADDR_W-1:0];
                        end
                        w_retire = 1'b1;
                        state_d  = S_FETCH;
                    end
                    default: state_d = S_FETCH;
                endcase
            end
            S_MEM: begin
                w_dmem_req = 1'b1;
                w_dmem_we  = (w_op == OP_SW);
                if (dmem_ack) begin
                    if (w_op == OP_SW) begin
                        w_retire = 1'b1;
                        state_d  = S_FETCH;
                    end else begin
                        mdr_d   = dmem_rdata;
                        state_d = S_WB;
                    end
                end
            end
            S_WB: begin
                w_rf_we    = 1'b1;
                w_rf_waddr = w_is_r ? w_rd : w_rt;
                w_rf_wdata = (w_op == OP_LW) ? mdr_q : aluout_q;
                w_retire   = 1'b1;
                state_d    = S_FETCH;
            end
            default: state_d = S_FETCH;
        endcase
    end

    // Control registers and datapath latches
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_FETCH;
            pc_q     <= RESET_PC;
            ir_q     <= '0;
            a_q      <= '0;
            b_q      <= '0;
            aluout_q <= '0;
            mdr_q    <= '0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            ir_q     <= ir_d;
            a_q      <= a_d;
            b_q      <= b_d;
            aluout_q <= aluout_d;
            mdr_q    <= mdr_d;
        end
    end

    // Register file write port; writes to R0 are dropped
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 32; i++) begin
                regs_q[i] <= '0;
            end
        end else if (w_rf_we && (w_rf_waddr != 5'd0)) begin
            regs_q[w_rf_waddr] <= w_rf_wdata;
        end
    end

    // Strobes are gated by rst_n so requests collapse the moment reset asserts
    assign imem_req   = rst_n & w_imem_req;
    assign dmem_req   = rst_n & w_dmem_req;
    assign dmem_we    = rst_n & w_dmem_we;
    assign retire     = rst_n & w_retire;
    assign illegal    = rst_n & w_illegal;
    assign imem_addr  = pc_q;
    assign pc_o       = pc_q;
    assign dmem_addr  = aluout_q[ADDR_W-1:0];
    assign dmem_wdata = b_q;

endmodule
`default_nettype wire

// File: tb/tb_mc_datapath.sv
`default_nettype none
// ============================================================================
// Module   : tb_mc_datapath
// Purpose  : Directed, table-driven bench for mc_datapath with simple
//            instruction/data memory responders and programmable wait states.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mc_datapath;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        imem_req, imem_ack;
    logic [31:0] imem_addr, imem_rdata;
    logic        dmem_req, dmem_we, dmem_ack;
    logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
    logic [31:0] pc_o;
    logic        retire, illegal;

    mc_datapath #(.DATA_W(32), .ADDR_W(32), .RESET_PC(32'h0)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_rdata (imem_rdata),
        .imem_ack   (imem_ack),
        .dmem_req   (dmem_req),
        .dmem_we    (dmem_we),
        .dmem_addr  (dmem_addr),
        .dmem_wdata (dmem_wdata),
        .dmem_rdata (dmem_rdata),
        .dmem_ack   (dmem_ack),
        .pc_o       (pc_o),
        .retire     (retire),
        .illegal    (illegal)
    );

    always #5 clk = ~clk;

    // Memory models
    logic [31:0] imem [128];
    logic [31:0] dmem [64];
    int          iwait, dwait, icnt, dcnt;

    assign imem_rdata = imem[imem_addr[8:2]];
    assign dmem_rdata = dmem[dmem_addr[7:2]];
    assign imem_ack   = imem_req && (icnt >= iwait);
    assign dmem_ack   = dmem_req && (dcnt >= dwait);

    always @(posedge clk) begin
        if (!rst_n) begin
            icnt <= 0;
            dcnt <= 0;
            for (int i = 0; i < 64; i++) dmem[i] <= '0;
        end else begin
            icnt <= (imem_req && !imem_ack) ? icnt + 1 : 0;
            dcnt <= (dmem_req && !dmem_ack) ? dcnt + 1 : 0;
            if (dmem_req && dmem_ack && dmem_we) dmem[dmem_addr[7:2]] <= dmem_wdata;
        end
    end

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] enc_i(logic [5:0] op, logic [4:0] rs, logic [4:0] rt, logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction
    function automatic logic [31:0] enc_r(logic [4:0] rs, logic [4:0] rt, logic [4:0] rd, logic [5:0] fn);
        return {6'h00, rs, rt, rd, 5'h00, fn};
    endfunction
    function automatic logic [31:0] enc_j(logic [25:0] t);
        return {6'h02, t};
    endfunction

    // Run one instruction from a FETCH-state sample point to the next one
    task automatic run_instr(output int cyc, output bit ill, output int mcyc,
                             output logic [31:0] maddr, output logic [31:0] mwdata,
                             output bit mwe, output bit stable);
        bit done;
        cyc = 1; ill = 0; mcyc = 0; maddr = '0; mwdata = '0; mwe = 0; stable = 1; done = 0;
        for (int k = 0; k < 200; k++) begin
            ill = ill | illegal;
            if (dmem_req) begin
                if (mcyc == 0) begin
                    maddr = dmem_addr; mwdata = dmem_wdata; mwe = dmem_we;
                end else if (dmem_addr !== maddr || dmem_wdata !== mwdata || dmem_we !== mwe) begin
                    stable = 0;
                end
                mcyc++;
            end
            if (retire) begin
                done = 1;
                break;
            end
            @(negedge clk);
            cyc++;
        end
        if (!done) begin
            n_cmp++;
            n_err++;
            $display("FAIL retire_timeout: got no retire expected retire within 200 cycles");
            cyc = -1;
        end
        @(negedge clk);
    endtask

    typedef struct {
        logic [31:0] pc;
        logic [31:0] ins;
        int          iw;
        int          cyc;
        bit          ill;
        logic [31:0] npc;
        logic [4:0]  ridx;
        logic [31:0] rval;
    } vec_t;

    vec_t vt[13];

    int          cyc, mcyc;
    bit          ill, mwe, stable;
    logic [31:0] maddr, mwdata;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        iwait = 0;
        dwait = 0;
        for (int i = 0; i < 128; i++) imem[i] = '0;

        vt[0]  = '{32'h000, enc_j(26'h40),                      0, 2, 1'b0, 32'h100, 5'd0,  32'h0};
        vt[1]  = '{32'h100, enc_i(6'h08, 5'd0, 5'd1, 16'd5),    0, 4, 1'b0, 32'h104, 5'd1,  32'h5};
        vt[2]  = '{32'h104, enc_i(6'h08, 5'd0, 5'd2, 16'hFFFD), 0, 4, 1'b0, 32'h108, 5'd2,  32'hFFFF_FFFD};
        vt[3]  = '{32'h108, enc_r(5'd1, 5'd2, 5'd3, 6'h20),     0, 4, 1'b0, 32'h10C, 5'd3,  32'h2};
        vt[4]  = '{32'h10C, enc_r(5'd2, 5'd1, 5'd5, 6'h2A),     0, 4, 1'b0, 32'h110, 5'd5,  32'h1};
        vt[5]  = '{32'h110, enc_r(5'd1, 5'd2, 5'd7, 6'h22),     0, 4, 1'b0, 32'h114, 5'd7,  32'h8};
        vt[6]  = '{32'h114, enc_r(5'd1, 5'd2, 5'd8, 6'h24),     1, 5, 1'b0, 32'h118, 5'd8,  32'h5};
        vt[7]  = '{32'h118, enc_r(5'd1, 5'd2, 5'd9, 6'h25),     0, 4, 1'b0, 32'h11C, 5'd9,  32'hFFFF_FFFD};
        vt[8]  = '{32'h11C, enc_i(6'h08, 5'd0, 5'd0, 16'd7),    0, 4, 1'b0, 32'h120, 5'd0,  32'h0};
        vt[9]  = '{32'h120, {6'h3F, 26'h0},                     2, 4, 1'b1, 32'h124, 5'd1,  32'h5};
        vt[10] = '{32'h124, enc_r(5'd1, 5'd2, 5'd11, 6'h21),    0, 2, 1'b1, 32'h128, 5'd11, 32'h0};
        vt[11] = '{32'h128, enc_i(6'h04, 5'd1, 5'd2, 16'd5),    0, 3, 1'b0, 32'h12C, 5'd3,  32'h2};
        vt[12] = '{32'h12C, enc_i(6'h04, 5'd1, 5'd1, 16'd1),    0, 3, 1'b0, 32'h134, 5'd10, 32'h0};
        for (int i = 0; i < 13; i++) imem[vt[i].pc[8:2]] = vt[i].ins;
        imem[32'h130 >> 2] = enc_i(6'h08, 5'd0, 5'd10, 16'd99);
        imem[32'h134 >> 2] = enc_i(6'h2B, 5'd0, 5'd3, 16'd8);
        imem[32'h138 >> 2] = enc_i(6'h23, 5'd0, 5'd4, 16'd8);
        imem[32'h13C >> 2] = enc_i(6'h23, 5'd0, 5'd6, 16'd8);

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_imem_req", {31'b0, imem_req}, 32'h0);
        chk("rst_dmem_req", {31'b0, dmem_req}, 32'h0);
        chk("rst_dmem_we",  {31'b0, dmem_we},  32'h0);
        chk("rst_retire",   {31'b0, retire},   32'h0);
        chk("rst_illegal",  {31'b0, illegal},  32'h0);
        chk("rst_pc",       pc_o,              32'h0);
        rst_n = 1'b1;
        #1;
        chk("post_rst_fetch", {31'b0, imem_req}, 32'h1);

        // Table-driven instruction vectors
        for (int i = 0; i < 13; i++) begin
            chk($sformatf("v%0d_pc", i), pc_o, vt[i].pc);
            iwait = vt[i].iw;
            run_instr(cyc, ill, mcyc, maddr, mwdata, mwe, stable);
            iwait = 0;
            chk($sformatf("v%0d_cycles", i), 32'(cyc), 32'(vt[i].cyc));
            chk($sformatf("v%0d_illegal", i), {31'b0, ill}, {31'b0, vt[i].ill});
            chk($sformatf("v%0d_next_pc", i), pc_o, vt[i].npc);
            chk($sformatf("v%0d_reg", i), dut.regs_q[vt[i].ridx], vt[i].rval);
        end

        // SW r3,8(r0) with two data wait states
        dwait = 2;
        run_instr(cyc, ill, mcyc, maddr, mwdata, mwe, stable);
        chk("sw_cycles",   32'(cyc),  32'd6);
        chk("sw_memcyc",   32'(mcyc), 32'd3);
        chk("sw_addr",     maddr,     32'h8);
        chk("sw_wdata",    mwdata,    32'h2);
        chk("sw_we",       {31'b0, mwe},    32'h1);
        chk("sw_stable",   {31'b0, stable}, 32'h1);
        chk("sw_mem",      dmem[2],   32'h2);

        // LW r4,8(r0) with two data wait states
        run_instr(cyc, ill, mcyc, maddr, mwdata, mwe, stable);
        chk("lw_cycles",   32'(cyc),  32'd7);
        chk("lw_we",       {31'b0, mwe},    32'h0);
        chk("lw_stable",   {31'b0, stable}, 32'h1);
        chk("lw_r4",       dut.regs_q[4], 32'h2);
        chk("lw_next_pc",  pc_o,      32'h13C);

        // Reset while LW r6 waits in MEM
        dwait = 1000;
        for (int k = 0; k < 10; k++) begin
            if (dmem_req) break;
            @(negedge clk);
        end
        repeat (2) @(negedge clk);
        chk("mem_pending_req", {31'b0, dmem_req}, 32'h1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_dmem_req", {31'b0, dmem_req}, 32'h0);
        chk("arst_imem_req", {31'b0, imem_req}, 32'h0);
        chk("arst_pc",       pc_o,              32'h0);
        chk("arst_r6",       dut.regs_q[6],     32'h0);
        dwait = 0;
        imem[0] = enc_j(26'h4);
        imem[4] = enc_i(6'h04, 5'd1, 5'd1, 16'hFFFF);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("rerst_fetch_addr", imem_addr, 32'h0);
        chk("rerst_fetch_req",  {31'b0, imem_req}, 32'h1);

        // J to 0x10 then BEQ self-loop twice
        run_instr(cyc, ill, mcyc, maddr, mwdata, mwe, stable);
        chk("j10_cycles", 32'(cyc), 32'd2);
        chk("j10_pc",     pc_o,     32'h10);
        for (int r = 0; r < 2; r++) begin
            run_instr(cyc, ill, mcyc, maddr, mwdata, mwe, stable);
            chk($sformatf("beq_loop%0d_cycles", r), 32'(cyc), 32'd3);
            chk($sformatf("beq_loop%0d_pc", r),     pc_o,     32'h10);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mc_datapath.md
Name: mc_datapath

Overview:
- Multi-cycle successor to the single-cycle MIPS datapath top.
- Executes one instruction over 2-5 states instead of one cycle.
- Instruction and data memories are external, behind request/acknowledge handshakes, so wait states are supported. The register file is internal.
- Parametrised in data width, address width and reset vector; adds branch, jump, load writeback and an illegal-opcode report, which the single-cycle top lacks.

Parameters:
- DATA_W, 32: register and ALU width. Must be >= 16. The 16-bit immediate is sign-extended to DATA_W.
- ADDR_W, 32: PC and memory address width. Must be <= DATA_W.
- RESET_PC, 0: PC value loaded on reset. Must be a multiple of 4.

Ports:
- clk, in, 1: clock, rising edge.
- rst_n, in, 1: asynchronous active-low reset.
- imem_req, out, 1: instruction fetch request.
- imem_addr, out, ADDR_W: fetch address (the PC).
- imem_rdata, in, 32: instruction word. Valid when imem_ack=1.
- imem_ack, in, 1: fetch complete.
- dmem_req, out, 1: data access request.
- dmem_we, out, 1: 1 = store, 0 = load.
- dmem_addr, out, ADDR_W: ALU result [ADDR_W-1:0].
- dmem_wdata, out, DATA_W: rt value.
- dmem_rdata, in, DATA_W: load data. Valid when dmem_ack=1.
- dmem_ack, in, 1: data access complete.
- pc_o, out, ADDR_W: current PC.
- retire, out, 1: one-cycle pulse in the final state of each instruction, including illegal ones.
- illegal, out, 1: one-cycle pulse when an unsupported opcode or funct is decoded.

Behaviour:
- Reset (asynchronous, rst_n=0):
  - state=FETCH, PC=RESET_PC.
  - imem_req=0, dmem_req=0, dmem_we=0, retire=0, illegal=0.
  - Instruction register (IR) = 0; A, B and ALUOut registers = 0; all 32 registers = 0.
  - Reset mid-operation abandons the instruction: no register write, and request lines drop asynchronously.
- Handshake:
  - A req, once raised, stays high with stable address/data until the edge on which ack=1 is sampled.
  - Ack may be high in the first req cycle, giving zero wait states.
  - An ack while req=0 is ignored.
- Supported instructions:
  - R-type (op 0x00) with funct ADD 0x20, SUB 0x22, AND 0x24, OR 0x25, SLT 0x2A (signed).
  - ADDI 0x08, LW 0x23, SW 0x2B, BEQ 0x04, J 0x02.
  - Arithmetic wraps modulo 2^DATA_W with no overflow trap.
- FSM states:
  - FETCH: imem_req=1. On ack: IR<=imem_rdata, PC<=PC+4 (wraps modulo 2^ADDR_W), go to DECODE.
  - DECODE:
    - A<=R[rs], B<=R[rt].
    - ALUOut<=PC+(sext(imm)<<2), the branch target.
    - J: PC<={PC[ADDR_W-1:28], IR[25:0], 2'b00}, truncated/extended to ADDR_W; retire=1; go to FETCH.
    - Illegal: illegal=1, retire=1, go to FETCH. The instruction behaves as a NOP with PC already advanced.
    - Otherwise go to EXEC.
  - EXEC:
    - R-type: ALUOut<=A op B, go to WB.
    - ADDI/LW/SW: ALUOut<=A+sext(imm). ADDI goes to WB; LW and SW go to MEM.
    - BEQ: if A==B then PC<=ALUOut; retire=1; go to FETCH.
  - MEM: dmem_req=1, dmem_we=(SW). On ack: SW sets retire=1 and goes to FETCH; LW latches MDR<=dmem_rdata and goes to WB.
  - WB: write R[rd] (R-type), R[rt] (ADDI) or MDR (LW); retire=1; go to FETCH.
- Register file:
  - R0 always reads 0; writes to R0 are discarded.
  - Reads in DECODE see all writes from earlier instructions, since WB always precedes the next DECODE.
- Latency with zero wait states:
  - J / illegal: 2 cycles.
  - BEQ: 3 cycles.
  - R-type / ADDI / SW: 4 cycles.
  - LW: 5 cycles.
  - Each wait cycle on imem or dmem adds 1.
- Memory addresses are not checked for alignment; the low two bits pass through unchanged.

Test Plan:
- Reset then imem_ack tied 1 with program ADDI r1,r0,5; ADDI r2,r0,-3; ADD r3,r1,r2 -> r3=2, retire pulses at cycles 4, 8 and 12, and PC=RESET_PC+12.
- SW r3,8(r0) then LW r4,8(r0), with dmem_ack delayed 2 cycles -> dmem_addr=8 and wdata=2 held stable for 3 cycles, then r4=2; LW takes 7 cycles.
- BEQ r1,r1,-1 at PC 0x10 -> PC=0x10 after 3 cycles (self-loop); BEQ r1,r2 with unequal operands -> PC=0x14.
- J 0x40 at PC 0x0 -> next imem_addr=0x100, 2 cycles. Op 0x3F -> illegal and retire pulse together, no register changes, PC+4.
- SLT r5,r2,r1 with r2=-3, r1=5 -> r5=1. ADDI r0,r0,7 -> r0 still reads 0.
- rst_n pulled low while in MEM for LW r6 with ack pending -> dmem_req drops immediately, r6 is unchanged, and the first post-reset fetch is at RESET_PC.
